// File: rtl/pong_match_controller.sv
// pong_match_controller: Pong match sequencer that gates paddles and ball, counts serve/point frames, scores and detects the winner.
module pong_match_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       paddle_run,
    output logic       ball_run,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state_n;
    logic [7:0] count, count_n;
    logic [3:0] left_n, right_n;
    logic [3:0] left_inc, right_inc;
    logic       dir_n, winner_n, start_q, start_pulse;

    assign start_pulse = start & ~start_q;
    assign left_inc    = score_left + 4'd1;
    assign right_inc   = score_right + 4'd1;

    always_comb begin
        state_n  = state_t'(state);
        count_n  = count;
        left_n   = score_left;
        right_n  = score_right;
        dir_n    = serve_dir;
        winner_n = winner;
        case (state)
            IDLE, GAME_OVER: if (start_pulse) begin
                state_n  = SERVE;
                left_n   = 4'd0;
                right_n  = 4'd0;
                dir_n    = 1'b1;
                winner_n = 1'b0;
                count_n  = SERVE_LOAD;
            end
            SERVE, POINT: if (frame_tick) begin
                // an expired POINT freeze reloads the counter for the next serve
                state_n = count != 8'd0 ? state_t'(state) : (state == SERVE ? PLAY : SERVE);
                count_n = count != 8'd0 ? count - 8'd1 : (state == SERVE ? count : SERVE_LOAD);
            end
            PLAY: if (miss_left && miss_right) begin
                state_n = POINT;
                count_n = POINT_LOAD;
            end else if (miss_left) begin
                right_n  = right_inc;
                dir_n    = 1'b0;
                winner_n = right_inc == WIN;
                state_n  = right_inc == WIN ? GAME_OVER : POINT;
                count_n  = POINT_LOAD;
            end else if (miss_right) begin
                left_n  = left_inc;
                dir_n   = 1'b1;
                state_n = left_inc == WIN ? GAME_OVER : POINT;
                count_n = POINT_LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 8'd0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            serve_dir   <= 1'b1;
            winner      <= 1'b0;
            start_q     <= 1'b0;
            paddle_run  <= 1'b0;
            ball_run    <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            score_left  <= left_n;
            score_right <= right_n;
            serve_dir   <= dir_n;
            winner      <= winner_n;
            start_q     <= start;
            paddle_run  <= state_n == SERVE || state_n == PLAY;
            ball_run    <= state_n == PLAY;
            game_over   <= state_n == GAME_OVER;
        end
    end
endmodule

// File: tb/tb_pong_match_controller.sv
// tb_pong_match_controller: table-driven scoreboard bench for the Pong match sequencer.
module tb_pong_match_controller;
    logic       clock = 1'b0, reset = 1'b1, frame_tick = 1'b0, start = 1'b0;
    logic       miss_left = 1'b0, miss_right = 1'b0;
    logic       paddle_run, ball_run, serve_dir, game_over, winner;
    logic [3:0] score_left, score_right;
    logic [2:0] state;

    localparam logic [2:0] IDL = 3'd0, SRV = 3'd1, PLY = 3'd2, PNT = 3'd3, GOV = 3'd4;

    typedef struct {
        int          n;
        logic        rs, ft, st, ml, mr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0, failures = 0;

    pong_match_controller dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .miss_left(miss_left), .miss_right(miss_right), .paddle_run(paddle_run),
        .ball_run(ball_run), .serve_dir(serve_dir), .score_left(score_left),
        .score_right(score_right), .game_over(game_over), .winner(winner), .state(state)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] pk(logic [2:0] s, logic pr, logic br, logic sd,
                                       logic [3:0] sl, logic [3:0] sr, logic go, logic w);
        return {s, pr, br, sd, sl, sr, go, w};
    endfunction

    function automatic logic [15:0] actual();
        return {state, paddle_run, ball_run, serve_dir, score_left, score_right, game_over, winner};
    endfunction

    task automatic add(int n, logic rs, logic ft, logic st, logic ml, logic mr,
                       logic [15:0] e, string nm);
        vec_t v;
        v.n = n; v.rs = rs; v.ft = ft; v.st = st; v.ml = ml; v.mr = mr;
        v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        vec_t e;
        for (int c = 0; c < v.n; c++) begin
            @(negedge clock);
            reset = v.rs; frame_tick = v.ft; start = v.st; miss_left = v.ml; miss_right = v.mr;
            if (c == v.n - 1) sb.push_back(v);
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, actual(), e.exp);
            end
        end
    endtask

    initial begin
        add(2, 1, 0, 0, 0, 0, pk(IDL, 0, 0, 1, 0, 0, 0, 0), "reset");
        add(1, 0, 0, 1, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "start_edge");
        add(9, 0, 0, 1, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "start_held");
        add(1, 0, 0, 0, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "start_low");
        add(1, 0, 0, 1, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "start_in_serve");
        add(59, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "serve_59");
        add(1, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 1, 0, 0, 0, 0), "serve_60");
        add(5, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 1, 0, 0, 0, 0), "tick_in_play");
        add(1, 0, 0, 0, 1, 0, pk(PNT, 0, 0, 0, 0, 1, 0, 0), "miss_left");
        add(1, 0, 0, 0, 1, 1, pk(PNT, 0, 0, 0, 0, 1, 0, 0), "miss_in_point");
        add(89, 0, 1, 0, 0, 0, pk(PNT, 0, 0, 0, 0, 1, 0, 0), "point_89");
        add(1, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 0, 0, 1, 0, 0), "point_90");
        add(59, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 0, 0, 1, 0, 0), "serve2_59");
        add(1, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 0, 0, 1, 0, 0), "serve2_60");
        add(1, 0, 0, 0, 1, 1, pk(PNT, 0, 0, 0, 0, 1, 0, 0), "double_miss");
        add(90, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 0, 0, 1, 0, 0), "dm_point");
        add(60, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 0, 0, 1, 0, 0), "dm_serve");
        for (int k = 1; k < 7; k++) begin
            add(1, 0, 0, 0, 0, 1, pk(PNT, 0, 0, 1, 4'(k), 1, 0, 0), "left_point");
            add(90, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 1, 4'(k), 1, 0, 0), "left_freeze");
            add(60, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 1, 4'(k), 1, 0, 0), "left_serve");
        end
        add(1, 0, 0, 0, 0, 1, pk(GOV, 0, 0, 1, 7, 1, 1, 0), "left_wins");
        add(3, 0, 1, 0, 1, 0, pk(GOV, 0, 0, 1, 7, 1, 1, 0), "go_miss_left");
        add(3, 0, 1, 0, 0, 1, pk(GOV, 0, 0, 1, 7, 1, 1, 0), "go_miss_right");
        add(1, 0, 0, 1, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "go_restart");
        add(60, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 1, 0, 0, 0, 0), "r_serve");
        for (int k = 1; k < 7; k++) begin
            add(1, 0, 0, 0, 1, 0, pk(PNT, 0, 0, 0, 0, 4'(k), 0, 0), "right_point");
            add(90, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 0, 0, 4'(k), 0, 0), "right_freeze");
            add(60, 0, 1, 0, 0, 0, pk(PLY, 1, 1, 0, 0, 4'(k), 0, 0), "right_serve");
        end
        add(1, 0, 0, 0, 1, 0, pk(GOV, 0, 0, 0, 0, 7, 1, 1), "right_wins");
        add(1, 0, 0, 1, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "restart_clears");
        add(29, 0, 1, 0, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "count_to_30");
        add(1, 1, 1, 0, 0, 0, pk(IDL, 0, 0, 1, 0, 0, 0, 0), "reset_mid_serve");
        add(1, 0, 1, 0, 1, 0, pk(IDL, 0, 0, 1, 0, 0, 0, 0), "idle_miss_left");
        add(1, 0, 1, 0, 0, 1, pk(IDL, 0, 0, 1, 0, 0, 0, 0), "idle_miss_right");
        add(1, 0, 0, 1, 0, 0, pk(SRV, 1, 0, 1, 0, 0, 0, 0), "idle_start");
        add(1, 1, 0, 0, 0, 0, pk(IDL, 0, 0, 1, 0, 0, 0, 0), "reset_again");
        add(1, 0, 0, 0, 0, 0, pk(IDL, 0, 0, 1, 0, 0, 0, 0), "idle_hold");
        foreach (tbl[i]) run_vec(tbl[i]);
        // an illegal encoding must fall back to IDLE on the following edge
        @(negedge clock);
        force dut.state = 3'd6;
        #1 release dut.state;
        @(posedge clock);
        #1;
        check("illegal_state", actual(), pk(IDL, 0, 0, 1, 0, 0, 0, 0));
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_match_controller.md
Name: pong_match_controller

Overview:
Match sequencer for the Pong game. It gates the paddle and ball blocks through their run/hold inputs, counts serve and point-freeze delays in video frames, keeps both scores, and detects the end of the match. It sits between the VGA frame-timing logic, the ball's miss detection and the two paddle instances. Its paddle_run output drives the paddles' active-low reset directly: 0 holds a paddle at its start position.

Parameters:
WIN_SCORE, 7, points needed to win the match (1..15)
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released (1..255)
POINT_FRAMES, 90, frame ticks spent frozen in POINT after a score (1..255)

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame
start  input  1  start button, active-high level; the block edge-detects it internally
miss_left  input  1  one-cycle pulse: ball passed the left paddle, so the right player scores
miss_right  input  1  one-cycle pulse: ball passed the right paddle, so the left player scores
paddle_run  output  1  1 = paddles move; 0 = paddles held at start position
ball_run  output  1  1 = ball moves; 0 = ball held at serve position
serve_dir  output  1  direction of the next serve: 0 = toward left, 1 = toward right
score_left  output  4  left player score
score_right  output  4  right player score
game_over  output  1  high while in GAME_OVER
winner  output  1  0 = left won, 1 = right won; valid only while game_over = 1
state  output  3  encoded state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4

Behaviour:
- Reset is synchronous and active-high: clock and reset as decided. Reset values:
  - state = IDLE, all scores = 0, serve_dir = 1
  - paddle_run, ball_run, game_over, winner = 0
  - frame counter = 0, start_q = 0
  - Reset asserted in any state, including mid-countdown, returns to these values on the next edge.
- Start edge detection: start_q registers start every cycle. start_pulse = start & ~start_q. A held button yields exactly one pulse.
- Outputs are registered and decoded from the next-state value, so they change on the same edge as state.
  - paddle_run = 1 in SERVE and PLAY only.
  - ball_run = 1 in PLAY only.
  - game_over = 1 in GAME_OVER only.
- IDLE:
  - start_pulse -> SERVE.
  - On that edge: scores cleared, serve_dir = 1, counter = SERVE_FRAMES-1.
- SERVE:
  - Each frame_tick with counter != 0 decrements the counter.
  - A frame_tick with counter == 0 -> PLAY. SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY:
  - miss_left alone: score_right += 1, serve_dir = 0 (serve toward the player who conceded).
  - miss_right alone: score_left += 1, serve_dir = 1.
  - After a scoring miss: if the new score == WIN_SCORE -> GAME_OVER, winner = scorer (1 for right, 0 for left). Otherwise -> POINT with counter = POINT_FRAMES-1.
  - Both misses in the same cycle: no score change, serve_dir unchanged, -> POINT.
  - frame_tick is ignored in PLAY.
- POINT:
  - Counts frame ticks as SERVE does.
  - frame_tick with counter == 0 -> SERVE, counter = SERVE_FRAMES-1.
- GAME_OVER:
  - Scores, winner and serve_dir are frozen.
  - start_pulse -> SERVE with scores cleared, serve_dir = 1, winner = 0, counter = SERVE_FRAMES-1.
- Ignored inputs:
  - Misses outside PLAY.
  - start outside IDLE and GAME_OVER.
- Score arithmetic is 4-bit unsigned and can never exceed WIN_SCORE, because reaching WIN_SCORE forces GAME_OVER.
- Reaching a score of 15 when WIN_SCORE=15 must not wrap.
- Unused state encodings (5..7) recover to IDLE on the next edge.

Test Plan:
- Reset then start held high for 10 cycles -> exactly one transition IDLE->SERVE. paddle_run=1, ball_run=0. After exactly 60 frame_ticks: state=PLAY, ball_run=1.
- In PLAY, pulse miss_left -> next edge: score_right=1, serve_dir=0, state=POINT, paddle_run=0, ball_run=0. After 90 frame_ticks: SERVE. After 60 more: PLAY.
- Drive miss_right 7 times, each followed by POINT/SERVE -> after the 7th: state=GAME_OVER, score_left=7, winner=0, game_over=1. Further misses leave the scores unchanged.
- In PLAY, miss_left and miss_right in the same cycle -> state=POINT, both scores and serve_dir unchanged.
- In SERVE with counter at 30, assert reset for one cycle -> next edge: state=IDLE, outputs at reset values. A misses pulse and a frame_tick in IDLE cause no change.
- In GAME_OVER, pulse start -> SERVE, scores=0, winner=0, game_over=0. Force state=6 -> IDLE next edge.
